// File: rtl/fma16_mul_seq_if.sv
// Operand/result bus between the upstream source, this multiplier and the FMA adder stage.
// Handshake: a transfer happens on a rising edge where valid and ready are both high; a source
// holds valid and its payload stable until that edge, and ready never depends on valid.
interface fma16_mul_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [15:0] y;
   logic [15:0] z;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] product;
   logic [15:0] x_q;
   logic [15:0] y_q;
   logic [15:0] z_q;
   logic [21:0] pm_raw;
   logic [6:0]  pe_raw;
   logic [1:0]  fsm_state;

   modport master (
      output in_valid, x, y, z, out_ready,
      input  in_ready, out_valid, product, x_q, y_q, z_q, pm_raw, pe_raw, fsm_state
   );

   modport slave (
      input  in_valid, x, y, z, out_ready,
      output in_ready, out_valid, product, x_q, y_q, z_q, pm_raw, pe_raw, fsm_state
   );
endinterface

// File: rtl/fma16_mul_seq.sv
// Iterative binary16 multiplier: 11-cycle shift-and-add significand product, then one
// normalise/round/pack cycle; results and captured operands feed the FMA adder stage.
module fma16_mul_seq #(
   parameter int MANT_W = 10,
   parameter int BIAS   = 15
) (
   input logic           clk,
   input logic           reset_n,
   fma16_mul_seq_if.slave bus
);
   localparam int SIG_W = MANT_W + 1;
   localparam int ACC_W = 2 * SIG_W;

   typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
   typedef enum logic [1:0] {SP_NONE, SP_NAN, SP_INF, SP_ZERO} spec_t;

   state_t             state;
   spec_t              spec;
   spec_t              spec_in;
   logic [3:0]         cnt;
   logic [ACC_W-1:0]   acc;
   logic [SIG_W-1:0]   mcand;
   logic [SIG_W-1:0]   mplier;
   logic signed [6:0]  pe;
   logic               sign;

   logic               x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
   logic signed [6:0]  e_n;
   logic signed [6:0]  e_r;
   logic [9:0]         m_n;
   logic               g_bit;
   logic               s_bit;
   logic [10:0]        m_sum;
   logic [15:0]        packed_res;

   assign bus.fsm_state = state;

   // Operand classification is done on the bus at accept so NORM only has to select.
   always_comb begin
      x_nan   = (bus.x[14:10] == 5'h1F) && (bus.x[9:0] != 10'h0);
      y_nan   = (bus.y[14:10] == 5'h1F) && (bus.y[9:0] != 10'h0);
      x_inf   = (bus.x[14:10] == 5'h1F) && (bus.x[9:0] == 10'h0);
      y_inf   = (bus.y[14:10] == 5'h1F) && (bus.y[9:0] == 10'h0);
      x_zero  = (bus.x[14:10] == 5'h00);
      y_zero  = (bus.y[14:10] == 5'h00);
      spec_in = SP_NONE;
      if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero))
         spec_in = SP_NAN;
      else if (x_inf || y_inf)
         spec_in = SP_INF;
      else if (x_zero || y_zero)
         spec_in = SP_ZERO;
   end

   always_comb begin
      if (acc[21]) begin
         e_n   = pe + 7'sd1;
         m_n   = acc[20:11];
         g_bit = acc[10];
         s_bit = |acc[9:0];
      end else begin
         e_n   = pe;
         m_n   = acc[19:10];
         g_bit = acc[9];
         s_bit = |acc[8:0];
      end
      m_sum = {1'b0, m_n} + {10'b0, g_bit & (s_bit | m_n[0])};
      // A carry out of the mantissa leaves m_sum[9:0] at zero, which is the required mantissa.
      e_r = e_n + $signed({6'b0, m_sum[10]});
      if (e_r >= 7'sd31)
         packed_res = {sign, 5'h1F, 10'h000};
      else if (e_r <= 7'sd0)
         packed_res = {sign, 15'h0000};
      else
         packed_res = {sign, e_r[4:0], m_sum[9:0]};
      case (spec)
         SP_NAN:  packed_res = 16'h7E00;
         SP_INF:  packed_res = {sign, 15'h7C00};
         SP_ZERO: packed_res = {sign, 15'h0000};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= IDLE;
         spec          <= SP_NONE;
         cnt           <= 4'd0;
         acc           <= '0;
         mcand         <= '0;
         mplier        <= '0;
         pe            <= '0;
         sign          <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.product   <= '0;
         bus.x_q       <= '0;
         bus.y_q       <= '0;
         bus.z_q       <= '0;
         bus.pm_raw    <= '0;
         bus.pe_raw    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && bus.in_ready) begin
                  state        <= MUL;
                  bus.in_ready <= 1'b0;
                  bus.x_q      <= bus.x;
                  bus.y_q      <= bus.y;
                  bus.z_q      <= bus.z;
                  mcand        <= {1'b1, bus.x[9:0]};
                  mplier       <= {1'b1, bus.y[9:0]};
                  acc          <= '0;
                  cnt          <= 4'd0;
                  pe           <= $signed({2'b00, bus.x[14:10]} + {2'b00, bus.y[14:10]} - 7'(BIAS));
                  sign         <= bus.x[15] ^ bus.y[15];
                  spec         <= spec_in;
               end
            end
            MUL: begin
               if (mplier[cnt])
                  acc <= acc + ({{SIG_W{1'b0}}, mcand} << cnt);
               if (cnt == 4'd10)
                  state <= NORM;
               else
                  cnt <= cnt + 4'd1;
            end
            NORM: begin
               bus.product   <= packed_res;
               bus.pm_raw    <= acc;
               bus.pe_raw    <= pe;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fma16_mul_seq.sv
// Directed and randomised checks of fma16_mul_seq against an integer reference model.
module tb_fma16_mul_seq;
   localparam int W = 93;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   fma16_mul_seq_if bus ();

   fma16_mul_seq dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

   // Expected word: {product, pm_raw, pe_raw, x, y, z}.
   function automatic logic [W-1:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
      int xe, ye, e, pm, sh, m, rem, half;
      logic s;
      logic [15:0] p;
      logic [6:0] pe7;
      logic an, bn, ai, bi, az, bz;
      xe   = int'(a[14:10]);
      ye   = int'(b[14:10]);
      pm   = int'({1'b1, a[9:0]}) * int'({1'b1, b[9:0]});
      e    = xe + ye - 15;
      pe7  = e[6:0];
      s    = a[15] ^ b[15];
      sh   = (pm >= (1 << 21)) ? 11 : 10;
      e    = e + sh - 10;
      m    = pm >> sh;
      rem  = pm & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && m[0])) m = m + 1;
      if (m == 2048) begin
         m = 1024;
         e = e + 1;
      end
      if (e >= 31)     p = {s, 15'h7C00};
      else if (e <= 0) p = {s, 15'h0000};
      else             p = {s, e[4:0], m[9:0]};
      an = (xe == 31) && (a[9:0] != 0);
      bn = (ye == 31) && (b[9:0] != 0);
      ai = (xe == 31) && (a[9:0] == 0);
      bi = (ye == 31) && (b[9:0] == 0);
      az = (xe == 0);
      bz = (ye == 0);
      if (an || bn || (ai && bz) || (bi && az)) p = 16'h7E00;
      else if (ai || bi)                        p = {s, 15'h7C00};
      else if (az || bz)                        p = {s, 15'h0000};
      return {p, pm[21:0], pe7, a, b, c};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic chk_fields(input string tag, input logic [W-1:0] e);
      chk({tag, "_product"}, 32'(bus.product), 32'(e[92:77]));
      chk({tag, "_pm_raw"},  32'(bus.pm_raw),  32'(e[76:55]));
      chk({tag, "_pe_raw"},  32'(bus.pe_raw),  32'(e[54:48]));
      chk({tag, "_x_q"},     32'(bus.x_q),     32'(e[47:32]));
      chk({tag, "_y_q"},     32'(bus.y_q),     32'(e[31:16]));
      chk({tag, "_z_q"},     32'(bus.z_q),     32'(e[15:0]));
   endtask

   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                         input int hold);
      logic [W-1:0] e;
      int lat;
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) ok = 1'b1;
      end
      chk("in_ready_idle", 32'(ok), 32'd1);
      if (!ok) return;
      exp_q.push_back(model(a, b, c));
      bus.in_valid = 1'b1;
      bus.x = a;
      bus.y = b;
      bus.z = c;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.x = 16'($urandom);
      bus.y = 16'($urandom);
      bus.z = 16'($urandom);
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (bus.out_valid === 1'b1) ok = 1'b1;
      end
      // Edges from the accepting edge to the first edge where the consumer can take the result.
      chk("latency", 32'(lat + 1), 32'd13);
      if (!ok) begin
         void'(exp_q.pop_front());
         return;
      end
      for (int i = 0; i < hold; i++) begin
         chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
         chk_fields("hold", exp_q[0]);
         @(posedge clk);
         @(negedge clk);
      end
      e = exp_q.pop_front();
      chk_fields("result", e);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("in_ready_after", 32'(bus.in_ready), 32'd1);
      chk("out_valid_after", 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      logic seen;
      logic [15:0] ra, rb;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.x         = '0;
      bus.y         = '0;
      bus.z         = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_product",   32'(bus.product),   32'd0);
      chk("rst_pm_raw",    32'(bus.pm_raw),    32'd0);
      chk("rst_pe_raw",    32'(bus.pe_raw),    32'd0);
      reset_n = 1'b1;

      run_op(16'h3E00, 16'h4000, 16'hABCD, 5);
      run_op(16'h3C01, 16'h3E00, 16'h1111, 0);
      run_op(16'h3C03, 16'h3E00, 16'h2222, 0);
      run_op(16'h7BFF, 16'h4000, 16'h3333, 0);
      run_op(16'hFBFF, 16'h4000, 16'h4444, 0);
      run_op(16'h7C00, 16'h0000, 16'h5555, 0);
      run_op(16'h7E00, 16'h3C00, 16'h6666, 0);
      run_op(16'hBC00, 16'h0000, 16'h7777, 0);
      run_op(16'h7C00, 16'hC000, 16'h8888, 0);
      run_op(16'h0400, 16'h0400, 16'h9999, 1);
      for (int i = 0; i < 6; i++) begin
         ra = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
         rb = {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
         run_op(ra, rb, 16'($urandom), 0);
      end

      // Abort an operation in MUL cycle 5 and make sure nothing is ever emitted for it.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.x = 16'h3E00;
      bus.y = 16'h4000;
      bus.z = 16'hABCD;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_product",   32'(bus.product),   32'd0);
      chk("abort_pm_raw",    32'(bus.pm_raw),    32'd0);
      chk("abort_pe_raw",    32'(bus.pe_raw),    32'd0);
      chk("abort_x_q",       32'(bus.x_q),       32'd0);
      chk("abort_z_q",       32'(bus.z_q),       32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen = 1'b1;
      end
      chk("abort_no_out_valid", 32'(seen), 32'd0);

      run_op(16'h4500, 16'hC200, 16'h0F0F, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
